// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants (word width, NOP and HALT encodings) and the next-PC select type.
`ifndef WORD_LEN
`define WORD_LEN 16
`endif
`ifndef NOP_INSTR
`define NOP_INSTR 16'h0000
`endif
`ifndef OP_HALT
`define OP_HALT 4'b1111
`endif

package fetch_stage_pkg;
   localparam int WORD_W = `WORD_LEN;
   localparam logic [WORD_W-1:0] NOP_WORD = `NOP_INSTR;
   localparam logic [3:0] HALT_OPCODE = `OP_HALT;

   typedef enum logic [1:0] {
      PC_HOLD = 2'd0,
      PC_INC  = 2'd1,
      PC_LOAD = 2'd2
   } pc_sel_t;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: synchronous reset, load, hold or modulo-2^WORD_W increment.
module fetch_stage_pc_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC   = '0,
   parameter int                INSTR_STEP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  pc_sel_t           sel,
   input  logic [WORD_W-1:0] load_addr,
   output logic [WORD_W-1:0] pc
);
   localparam logic [WORD_W-1:0] STEP = WORD_W'(INSTR_STEP);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else begin
         case (sel)
            PC_LOAD: pc <= load_addr;
            PC_INC:  pc <= pc + STEP;
            default: pc <= pc;
         endcase
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives the PC to instruction memory and registers {pc, instruction} into IF/ID.
// Optional HALT detection is built when FETCH_HALT_EN is defined; otherwise halted is tied 0.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC   = '0,
   parameter int                INSTR_STEP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] branch_addr,
   input  logic              flush,
   input  logic [WORD_W-1:0] instruction,
   output logic [WORD_W-1:0] pc_out,
   output logic [WORD_W-1:0] if_id_pc,
   output logic [WORD_W-1:0] if_id_pc_next,
   output logic [WORD_W-1:0] if_id_instruction,
   output logic              if_id_valid,
   output logic              halted
);
   localparam logic [WORD_W-1:0] STEP = WORD_W'(INSTR_STEP);

   pc_sel_t pc_sel;
   logic    halt_now;
   logic    bubble;

`ifdef FETCH_HALT_EN
   // A HALT being captured this edge also stops the PC so it keeps pointing at the HALT.
   assign halt_now = !freeze && !flush && !branch_taken && !halted
                     && (instruction[WORD_W-1 -: 4] == HALT_OPCODE);

   always_ff @(posedge clk) begin
      if (rst || branch_taken) begin
         halted <= 1'b0;
      end else if (halt_now) begin
         halted <= 1'b1;
      end
   end
`else
   assign halt_now = 1'b0;
   assign halted   = 1'b0;
`endif

   always_comb begin
      pc_sel = PC_INC;
      if (branch_taken) begin
         pc_sel = PC_LOAD;
      end else if (freeze || halted || halt_now) begin
         pc_sel = PC_HOLD;
      end
   end

   fetch_stage_pc_reg #(
      .RESET_PC   (RESET_PC),
      .INSTR_STEP (INSTR_STEP)
   ) u_pc_reg (
      .clk       (clk),
      .rst       (rst),
      .sel       (pc_sel),
      .load_addr (branch_addr),
      .pc        (pc_out)
   );

   assign bubble = rst || branch_taken || flush;

   always_ff @(posedge clk) begin
      if (bubble) begin
         if_id_pc          <= '0;
         if_id_instruction <= NOP_WORD;
         if_id_valid       <= 1'b0;
      end else if (freeze) begin
         if_id_pc          <= if_id_pc;
         if_id_instruction <= if_id_instruction;
         if_id_valid       <= if_id_valid;
      end else if (halted) begin
         if_id_pc          <= '0;
         if_id_instruction <= NOP_WORD;
         if_id_valid       <= 1'b0;
      end else begin
         if_id_pc          <= pc_out;
         if_id_instruction <= instruction;
         if_id_valid       <= 1'b1;
      end
   end

   assign if_id_pc_next = if_id_pc + STEP;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, freeze, flush, branch, wrap and HALT.
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freeze = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_addr = 16'h0;
   logic        flush = 1'b0;
   logic [15:0] instruction;
   logic [15:0] pc_out, if_id_pc, if_id_pc_next, if_id_instruction;
   logic        if_id_valid, halted;

   int errors = 0;
   int checks = 0;

   logic [15:0] rom [16];
   logic [48:0] obs;
   logic [48:0] exp_v;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .flush(flush), .instruction(instruction),
      .pc_out(pc_out), .if_id_pc(if_id_pc), .if_id_pc_next(if_id_pc_next),
      .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid), .halted(halted)
   );

   // Combinational instruction memory: table below 64, {2, pc[11:0]} above.
   always_comb begin
      if (pc_out < 16'd64) instruction = rom[pc_out[5:2]];
      else                 instruction = {4'h2, pc_out[11:0]};
   end

   assign obs = {pc_out, if_id_pc, if_id_instruction, if_id_valid};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      exp_v = {16'd0, 16'd0, 16'h0000, 1'b0};
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_state got=%h want=%h", obs, exp_v);
      end
      checks++;
      if (if_id_pc_next !== 16'd4) begin
         errors++;
         $display("FAIL reset_pc_next got=%h want=%h", if_id_pc_next, 16'd4);
      end
      checks++;
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_halted got=%b want=0", halted);
      end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         exp_v = {16'(4 * (i + 1)), 16'(4 * i), rom[i], 1'b1};
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL seq_%0d got=%h want=%h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_freeze();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      step();
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         exp_v = {16'd8, 16'd4, 16'h300F, 1'b1};
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL freeze_hold_%0d got=%h want=%h", i, obs, exp_v);
         end
      end
      freeze = 1'b0;
      step();
      checks++;
      exp_v = {16'd12, 16'd8, 16'h3F07, 1'b1};
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL freeze_resume0 got=%h want=%h", obs, exp_v);
      end
      step();
      checks++;
      exp_v = {16'd16, 16'd12, 16'h0310, 1'b1};
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL freeze_resume1 got=%h want=%h", obs, exp_v);
      end
   endtask

   task automatic test_flush();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      exp_v = {16'd24, 16'd0, 16'h0000, 1'b0};
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL flush_bubble got=%h want=%h", obs, exp_v);
      end
      step();
      checks++;
      exp_v = {16'd28, 16'd24, 16'h1018, 1'b1};
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL flush_after got=%h want=%h", obs, exp_v);
      end
   endtask

   task automatic test_branch(input logic with_freeze);
      branch_taken = 1'b1;
      branch_addr  = 16'd48;
      freeze       = with_freeze;
      step();
      branch_taken = 1'b0;
      freeze       = 1'b0;
      checks++;
      exp_v = {16'd48, 16'd0, 16'h0000, 1'b0};
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL branch_redirect frz=%b got=%h want=%h", with_freeze, obs, exp_v);
      end
      step();
      checks++;
      exp_v = {16'd52, 16'd48, 16'h1030, 1'b1};
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL branch_target frz=%b got=%h want=%h", with_freeze, obs, exp_v);
      end
   endtask

   task automatic goto_28();
      branch_taken = 1'b1;
      branch_addr  = 16'd28;
      step();
      branch_taken = 1'b0;
   endtask

   task automatic test_wrap();
      branch_taken = 1'b1;
      branch_addr  = 16'hFFFC;
      step();
      branch_taken = 1'b0;
      step();
      checks++;
      exp_v = {16'h0000, 16'hFFFC, 16'h2FFC, 1'b1};
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL wrap_pc got=%h want=%h", obs, exp_v);
      end
      checks++;
      if (if_id_pc_next !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_pc_next got=%h want=0000", if_id_pc_next);
      end
   endtask

   task automatic test_halt();
      branch_taken = 1'b1;
      branch_addr  = 16'd32;
      step();
      branch_taken = 1'b0;
      step();
`ifdef FETCH_HALT_EN
      checks++;
      exp_v = {16'd32, 16'd32, 16'hF000, 1'b1};
      if (obs !== exp_v || halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_capture got=%h/%b want=%h/1", obs, halted, exp_v);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         exp_v = {16'd32, 16'd0, 16'h0000, 1'b0};
         if (obs !== exp_v || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_hold_%0d got=%h/%b want=%h/1", i, obs, halted, exp_v);
         end
      end
      branch_taken = 1'b1;
      branch_addr  = 16'd8;
      step();
      branch_taken = 1'b0;
      checks++;
      exp_v = {16'd8, 16'd0, 16'h0000, 1'b0};
      if (obs !== exp_v || halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_release got=%h/%b want=%h/0", obs, halted, exp_v);
      end
      step();
      checks++;
      exp_v = {16'd12, 16'd8, 16'h3F07, 1'b1};
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL halt_resume got=%h want=%h", obs, exp_v);
      end
`else
      checks++;
      exp_v = {16'd36, 16'd32, 16'hF000, 1'b1};
      if (obs !== exp_v || halted !== 1'b0) begin
         errors++;
         $display("FAIL nohalt_pass got=%h/%b want=%h/0", obs, halted, exp_v);
      end
      step();
      checks++;
      exp_v = {16'd40, 16'd36, 16'h1024, 1'b1};
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL nohalt_next got=%h want=%h", obs, exp_v);
      end
`endif
   endtask

   task automatic test_mid_reset();
      rst          = 1'b1;
      branch_taken = 1'b1;
      branch_addr  = 16'd40;
      step();
      rst          = 1'b0;
      branch_taken = 1'b0;
      checks++;
      exp_v = {16'd0, 16'd0, 16'h0000, 1'b0};
      if (obs !== exp_v || halted !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got=%h/%b want=%h/0", obs, halted, exp_v);
      end
   endtask

   initial begin
      rom[0]  = 16'h3709; rom[1]  = 16'h300F; rom[2]  = 16'h3F07; rom[3]  = 16'h0310;
      rom[4]  = 16'h1010; rom[5]  = 16'h1014; rom[6]  = 16'h1018; rom[7]  = 16'h101C;
      rom[8]  = 16'hF000; rom[9]  = 16'h1024; rom[10] = 16'h1028; rom[11] = 16'h102C;
      rom[12] = 16'h1030; rom[13] = 16'h1034; rom[14] = 16'h1038; rom[15] = 16'h103C;
      #2;
      test_reset();
      test_sequential();
      test_freeze();
      test_flush();
      test_branch(1'b0);
      goto_28();
      test_branch(1'b1);
      test_wrap();
      test_halt();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
